// File: rtl/io_timer_responder.sv
// 65C02 memory-mapped interval timer: 16-bit down counter, reload latch, CTRL/STATUS, irq and rdy wait states.
// Optional IO_TIMER_ATOMIC_READ_EN: a T_LO read snapshots counter[15:8] so T_HI reads are tear-free.
module io_timer_responder #(
    parameter int WAIT_STATES = 1,
    parameter int PRESCALE    = 1
) (
    input  logic       CLOCK_IN,
    input  logic       RESET,
    input  logic       io_sel,
    input  logic [3:0] address,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq,
    output logic       rdy
);

    localparam logic [7:0] WS_LOAD = 8'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] latch_q, latch_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        tf_q, tf_d;
    logic [7:0]  presc_q, presc_d;

    logic rdy_fsm;
    logic commit, wr;
    logic wr_tlo, wr_thi, wr_ctrl, wr_stat;
    logic tick, underflow;

    // Access FSM: a selected access is held off until ACCESS, where it commits.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rdy_fsm    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (io_sel && (WAIT_STATES > 0)) begin
                    rdy_fsm    = 1'b0;
                    wait_cnt_d = WS_LOAD;
                    state_d    = (WAIT_STATES > 1) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                rdy_fsm = 1'b0;
                if (!io_sel) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                    if (wait_cnt_q <= 8'd1) state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign rdy     = rdy_fsm | ~RESET;
    assign commit  = io_sel & rdy_fsm;
    assign wr      = commit & we;
    assign wr_tlo  = wr && (address == 4'd0);
    assign wr_thi  = wr && (address == 4'd1);
    assign wr_ctrl = wr && (address == 4'd2);
    assign wr_stat = wr && (address == 4'd3);

    assign tick      = ctrl_q[0] && (presc_q == PRE_MAX);
    assign underflow = tick && (cnt_q == 16'd0);

    // Timer first, then CPU writes layered on top so the bus wins collisions;
    // the one exception is a STATUS clear, which loses to an underflow set.
    always_comb begin
        presc_d = (!ctrl_q[0] || tick) ? 8'd0 : presc_q + 8'd1;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        tf_d    = tf_q;
        latch_d = latch_q;

        if (tick) begin
            if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
            else if (ctrl_q[1]) cnt_d = latch_q;
        end
        if (underflow && !ctrl_q[1]) ctrl_d[0] = 1'b0;

        if (wr_stat && data_in[0]) tf_d = 1'b0;
        if (underflow)             tf_d = 1'b1;

        if (wr_tlo) latch_d[7:0] = data_in;
        if (wr_ctrl) ctrl_d = data_in[2:0];
        if (wr_thi) begin
            latch_d[15:8] = data_in;
            cnt_d         = {data_in, latch_q[7:0]};
            tf_d          = 1'b0;
            presc_d       = 8'd0;
        end
    end

    always_ff @(posedge CLOCK_IN or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
            latch_q    <= 16'd0;
            cnt_q      <= 16'd0;
            ctrl_q     <= 3'd0;
            tf_q       <= 1'b0;
            presc_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            latch_q    <= latch_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            tf_q       <= tf_d;
            presc_q    <= presc_d;
        end
    end

`ifdef IO_TIMER_ATOMIC_READ_EN
    logic [7:0] snap_q, snap_d;

    always_comb begin
        snap_d = snap_q;
        if (commit && !we && (address == 4'd0)) snap_d = cnt_q[15:8];
    end

    always_ff @(posedge CLOCK_IN or negedge RESET) begin
        if (!RESET) snap_q <= 8'd0;
        else        snap_q <= snap_d;
    end
`endif

    always_comb begin
        data_out = 8'h00;
        if (io_sel) begin
            case (address)
                4'd0: data_out = cnt_q[7:0];
`ifdef IO_TIMER_ATOMIC_READ_EN
                4'd1: data_out = snap_q;
`else
                4'd1: data_out = cnt_q[15:8];
`endif
                4'd2: data_out = {5'b0, ctrl_q};
                4'd3: data_out = {tf_q & ctrl_q[2], 6'b0, tf_q};
                default: data_out = 8'h00;
            endcase
        end
    end

    assign irq = tf_q & ctrl_q[2];

endmodule

// File: tb/tb_io_timer_responder.sv
// Directed bench for io_timer_responder (WAIT_STATES=2, PRESCALE=1); honours IO_TIMER_ATOMIC_READ_EN.
module tb_io_timer_responder;

    logic       CLOCK_IN = 1'b0;
    logic       RESET;
    logic       io_sel;
    logic [3:0] address;
    logic       we;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       irq;
    logic       rdy;

    int         checks = 0;
    int         errors = 0;
    int         last_stalls = 0;
    logic [7:0] rv;

    io_timer_responder #(.WAIT_STATES(2), .PRESCALE(1)) dut (
        .CLOCK_IN (CLOCK_IN),
        .RESET    (RESET),
        .io_sel   (io_sel),
        .address  (address),
        .we       (we),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq),
        .rdy      (rdy)
    );

    always #5 CLOCK_IN = ~CLOCK_IN;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full bus cycle: present at a negedge, hold through the stall, commit on the next edge with rdy=1.
    task automatic bus_access(input logic w, input logic [3:0] a, input logic [7:0] d,
                              output logic [7:0] rd);
        int n;
        @(negedge CLOCK_IN);
        io_sel = 1'b1; we = w; address = a; data_in = d;
        n = 0;
        #1;
        while (rdy !== 1'b1 && n < 20) begin
            @(negedge CLOCK_IN);
            #1;
            n++;
        end
        if (n >= 20) check("rdy_timeout", {7'b0, rdy}, 8'h01);
        last_stalls = n;
        rd = data_out;
        @(posedge CLOCK_IN);
        #1;
        io_sel = 1'b0; we = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        bus_access(1'b1, a, d, dummy);
    endtask

    // Edge-free look at data_out: select is dropped again before any clock edge.
    task automatic peek_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        io_sel = 1'b1; we = 1'b0; address = a;
        #1;
        check(tag, data_out, exp);
        io_sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; io_sel = 1'b0; we = 1'b0; address = 4'd0; data_in = 8'h00;
        repeat (2) @(negedge CLOCK_IN);
        check("rst_rdy", {7'b0, rdy}, 8'h01);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_dout", data_out, 8'h00);
        io_sel = 1'b1; address = 4'd2;
        #1;
        check("rst_rdy_sel", {7'b0, rdy}, 8'h01);
        io_sel = 1'b0;
        @(negedge CLOCK_IN);
        RESET = 1'b1;

        // Wait states and CTRL readback
        wr_reg(4'd2, 8'h06);
        check("wr_stalls", 8'(last_stalls), 8'd2);
        bus_access(1'b0, 4'd2, 8'h00, rv);
        check("ctrl_read", rv, 8'h06);
        check("rd_stalls", 8'(last_stalls), 8'd2);
        @(negedge CLOCK_IN);
        #1;
        check("idle_rdy", {7'b0, rdy}, 8'h01);

        // Continuous mode, latch 3
        wr_reg(4'd0, 8'h03);
        wr_reg(4'd1, 8'h00);
        wr_reg(4'd2, 8'h07);
        @(negedge CLOCK_IN); peek_check("cont_c3", 4'd0, 8'h03);
        peek_check("cont_st0", 4'd3, 8'h00);
        @(negedge CLOCK_IN); peek_check("cont_c2", 4'd0, 8'h02);
        @(negedge CLOCK_IN); peek_check("cont_c1", 4'd0, 8'h01);
        @(negedge CLOCK_IN); peek_check("cont_c0", 4'd0, 8'h00);
        peek_check("cont_st_pre", 4'd3, 8'h00);
        @(negedge CLOCK_IN); peek_check("cont_reload", 4'd0, 8'h03);
        peek_check("cont_st_uf", 4'd3, 8'h81);
        check("cont_irq", {7'b0, irq}, 8'h01);
        wr_reg(4'd2, 8'h00);
        wr_reg(4'd3, 8'h01);
        @(negedge CLOCK_IN); peek_check("cont_st_clr", 4'd3, 8'h00);
        check("cont_irq_clr", {7'b0, irq}, 8'h00);

        // One-shot, latch 2
        wr_reg(4'd0, 8'h02);
        wr_reg(4'd1, 8'h00);
        wr_reg(4'd2, 8'h05);
        @(negedge CLOCK_IN); peek_check("os_c2", 4'd0, 8'h02);
        @(negedge CLOCK_IN); peek_check("os_c1", 4'd0, 8'h01);
        @(negedge CLOCK_IN); peek_check("os_c0", 4'd0, 8'h00);
        peek_check("os_st_pre", 4'd3, 8'h00);
        @(negedge CLOCK_IN); peek_check("os_st_uf", 4'd3, 8'h81);
        peek_check("os_ctrl", 4'd2, 8'h04);
        peek_check("os_hold_lo", 4'd0, 8'h00);
        @(negedge CLOCK_IN); peek_check("os_hold_lo2", 4'd0, 8'h00);
        peek_check("os_hold_hi", 4'd1, 8'h00);
        wr_reg(4'd3, 8'h01);
        @(negedge CLOCK_IN); peek_check("os_st_clr", 4'd3, 8'h00);
        check("os_irq_clr", {7'b0, irq}, 8'h00);

        // Collisions: underflow edges at E+4 and E+8 after the CTRL write edge E
        wr_reg(4'd0, 8'h03);
        wr_reg(4'd1, 8'h00);
        wr_reg(4'd2, 8'h07);
        @(negedge CLOCK_IN);
        wr_reg(4'd3, 8'h01);
        @(negedge CLOCK_IN); peek_check("col_st_set", 4'd3, 8'h81);
        peek_check("col_reload", 4'd0, 8'h03);
        wr_reg(4'd1, 8'h01);
        @(negedge CLOCK_IN); peek_check("col_thi_st", 4'd3, 8'h00);
        peek_check("col_thi_lo", 4'd0, 8'h03);
        peek_check("col_thi_hi", 4'd1, 8'h01);
        check("col_thi_irq", {7'b0, irq}, 8'h00);
        @(negedge CLOCK_IN); peek_check("col_thi_dec", 4'd0, 8'h02);
        wr_reg(4'd2, 8'h00);

        // Latch 0 with auto-reload underflows on every tick
        wr_reg(4'd0, 8'h00);
        wr_reg(4'd1, 8'h00);
        wr_reg(4'd2, 8'h03);
        @(negedge CLOCK_IN); peek_check("z_st0", 4'd3, 8'h00);
        @(negedge CLOCK_IN); peek_check("z_st1", 4'd3, 8'h01);
        peek_check("z_cnt", 4'd0, 8'h00);
        check("z_irq_masked", {7'b0, irq}, 8'h00);
        wr_reg(4'd2, 8'h00);
        wr_reg(4'd3, 8'h01);

        // Reset in the middle of a wait
        wr_reg(4'd0, 8'h34);
        wr_reg(4'd1, 8'h12);
        wr_reg(4'd2, 8'h06);
        @(negedge CLOCK_IN); peek_check("pre_rst_hi", 4'd1, 8'h12);
        peek_check("pre_rst_lo", 4'd0, 8'h34);
        address = 4'd0;
        #1;
        check("dout_unsel", data_out, 8'h00);
        @(negedge CLOCK_IN);
        io_sel = 1'b1; we = 1'b0; address = 4'd2;
        @(negedge CLOCK_IN);
        #1;
        check("wait_rdy", {7'b0, rdy}, 8'h00);
        RESET = 1'b0;
        #1;
        check("arst_rdy", {7'b0, rdy}, 8'h01);
        check("arst_irq", {7'b0, irq}, 8'h00);
        check("arst_ctrl", data_out, 8'h00);
        address = 4'd0;
        #1;
        check("arst_lo", data_out, 8'h00);
        address = 4'd1;
        #1;
        check("arst_hi", data_out, 8'h00);
        io_sel = 1'b0;
        @(negedge CLOCK_IN);
        RESET = 1'b1;
        bus_access(1'b0, 4'd2, 8'h00, rv);
        check("post_rst_ctrl", rv, 8'h00);
        check("post_rst_stalls", 8'(last_stalls), 8'd2);

        // io_sel dropped during WAIT: nothing commits
        @(negedge CLOCK_IN);
        io_sel = 1'b1; we = 1'b1; address = 4'd2; data_in = 8'h07;
        @(negedge CLOCK_IN);
        io_sel = 1'b0; we = 1'b0;
        repeat (3) @(negedge CLOCK_IN);
        peek_check("abort_ctrl", 4'd2, 8'h00);

        // Unmapped addresses
        wr_reg(4'd5, 8'hFF);
        @(negedge CLOCK_IN); peek_check("unmap_rd5", 4'd5, 8'h00);
        peek_check("unmap_ctrl", 4'd2, 8'h00);
        bus_access(1'b0, 4'd15, 8'h00, rv);
        check("unmap_rd15", rv, 8'h00);

        // T_LO read followed by ticks, then T_HI
        wr_reg(4'd0, 8'h00);
        wr_reg(4'd1, 8'h01);
        bus_access(1'b0, 4'd0, 8'h00, rv);
        check("snap_lo_rd", rv, 8'h00);
        wr_reg(4'd2, 8'h01);
        repeat (6) @(negedge CLOCK_IN);
        peek_check("snap_live_lo", 4'd0, 8'hFB);
`ifdef IO_TIMER_ATOMIC_READ_EN
        peek_check("snap_hi", 4'd1, 8'h01);
`else
        peek_check("live_hi", 4'd1, 8'h00);
`endif
        wr_reg(4'd2, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_timer_responder.md
Name: io_timer_responder

Overview:
- Memory-mapped I/O responder on the 65C02 system bus, selected by the address decoder's io_sel.
- Contains a 16-bit down-counting interval timer with reload latch, control and status registers.
- Produces the CPU's irq request and inserts wait states through rdy.

Parameters:
- WAIT_STATES, 1, RDY-low cycles inserted per selected access (0 = no stall).
- PRESCALE, 1, clock cycles per timer decrement (legal 1..255).

Ports:
- CLOCK_IN  in   1  system clock; all state updates on the rising edge.
- RESET     in   1  asynchronous, active-low reset.
- io_sel    in   1  chip select from the address decoder, active-high.
- address   in   4  CPU address bits [3:0].
- we        in   1  CPU write enable (1 = write).
- data_in   in   8  CPU write data.
- data_out  out  8  read data. Combinational from address while io_sel=1, else 0x00.
- irq       out  1  interrupt request to CPU, active-high level.
- rdy       out  1  CPU ready, 0 = stall.

Behaviour:
- Reset (RESET=0, async): latch=0x0000, counter=0x0000, CTRL=0x00, TF=0, prescaler=0, FSM=IDLE. Outputs: irq=0, rdy=1, data_out=0x00.
- Access FSM:
  - IDLE: if io_sel=1 and WAIT_STATES>0, rdy=0 combinationally, the wait counter loads WAIT_STATES-1, and the FSM goes to WAIT.
  - WAIT: rdy=0. The wait counter decrements each cycle; at 0 the FSM goes to ACCESS.
  - ACCESS: rdy=1. The access commits on this edge, then the FSM returns to IDLE.
  - WAIT_STATES=0: the FSM stays in IDLE, rdy is always 1, and an access commits on any edge with io_sel=1.
  - If io_sel drops during WAIT, the FSM returns to IDLE with nothing committed.
- Register map (commit = edge with io_sel=1 and rdy=1):
  - 0 T_LO: write sets latch[7:0]; read returns counter[7:0].
  - 1 T_HI: write sets latch[15:8], loads counter with {data_in, latch[7:0]}, clears TF and clears the prescaler. Read returns counter[15:8].
  - 2 CTRL: bit0 RUN, bit1 CONT (auto-reload), bit2 IE. Bits 7:3 read 0.
  - 3 STATUS: bit0 TF, bit7 = irq. Writing 1 to bit0 clears TF.
  - 4..15: reads return 0x00; writes are ignored.
- Timer:
  - While RUN=1, the prescaler counts 0..PRESCALE-1 and issues a tick on wrap. While RUN=0, the prescaler is held at 0.
  - On a tick with counter!=0: counter decrements by 1.
  - On a tick with counter==0 (underflow): TF<=1. If CONT=1, counter<=latch. If CONT=0, counter stays 0 and RUN<=0.
  - Counter arithmetic is modulo 2^16. A latch of 0x0000 with CONT=1 underflows on every tick.
- irq = TF & IE. It is registered-state derived, with no glitches from the bus.
- Simultaneous events:
  - T_HI write in the same cycle as an underflow: the write wins (counter loaded, TF=0).
  - STATUS clear in the same cycle as an underflow: the set wins (TF=1).
  - CTRL write of RUN=1 in the same cycle as an underflow clearing RUN: the CPU write wins.
- Reset asserted mid-wait or mid-count aborts immediately. rdy=1 while RESET=0.

Optional Feature:
- Macro IO_TIMER_ATOMIC_READ_EN.
- Defined:
  - A read commit of T_LO copies counter[15:8] into an 8-bit snapshot register (reset 0x00).
  - T_HI reads return the snapshot, giving a tear-free 16-bit read when T_LO is read first.
- Undefined: T_HI reads return live counter[15:8], and no snapshot register exists.

Test Plan:
- WAIT_STATES=2: io_sel=1 read at addr 2 -> rdy low exactly 2 cycles, high on the 3rd. FSM back to IDLE. data_out=CTRL value.
- Write latch 0x0003 (T_LO=0x03, T_HI=0x00), CTRL=0x07, PRESCALE=1 -> counter 3,2,1,0. TF=1 and irq=1 on the 4th tick edge after RUN. Counter reloads to 3.
- One-shot: CTRL=0x05, latch 0x0002 -> TF=1 after the 3rd tick. RUN reads 0 and the counter holds 0x0000. Write STATUS=0x01 -> TF=0, irq=0.
- Collision: STATUS=0x01 write on the underflow edge -> TF stays 1. T_HI=0x00 write on the underflow edge -> TF=0, counter=latch.
- Assert RESET mid-wait with counter at 0x1234 -> rdy=1, irq=0, counter=0x0000, CTRL=0x00 asynchronously.
- With IO_TIMER_ATOMIC_READ_EN: counter 0x0100, read T_LO (returns 0x00), wait 5 ticks, read T_HI -> returns 0x01, not 0x00.
